// File: rtl/axi_lite_slice_if.sv
// AXI-Lite channel bundle. Clock and reset travel with the bundle so that a block
// can take them from its upstream port.
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rstn
);
  // Each channel transfers a beat on the clock edge where valid && ready are both
  // high; the sender holds valid and payload stable until then, and a receiver's
  // ready never depends on its own valid input.
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;

  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;

  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, aw_prot, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input  b_valid, b_resp, output b_ready,
    output ar_valid, ar_addr, ar_prot, input ar_ready,
    input  r_valid, r_data, r_resp, output r_ready
  );

  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, aw_prot, output aw_ready,
    input  w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready,
    input  ar_valid, ar_addr, ar_prot, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready
  );
endinterface

// File: rtl/axi_lite_slice.sv
// AXI-Lite register slice: one independent in-order buffer per channel, plus
// outstanding-transaction counters that throttle AW/AR and flag unsolicited responses.
module axi_lite_slice_fifo #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             empty_o
);
  if (DEPTH == 0) begin : g_pass
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign out_data_o  = in_data_i;
    assign empty_o     = 1'b1;
  end else begin : g_buf
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

    // Ready looks only at the registered count, so a full buffer refuses a beat
    // even when it is being drained in the same cycle.
    assign in_ready_o  = (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rptr_q];
    assign empty_o     = (count_q == '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
      end
    end

    // Storage needs no reset: an empty count hides whatever it holds.
    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_q[wptr_q] <= in_data_i;
      end
    end
  end
endmodule

module axi_lite_slice #(
  parameter int AW_DEPTH = 1,
  parameter int W_DEPTH  = 1,
  parameter int B_DEPTH  = 1,
  parameter int AR_DEPTH = 1,
  parameter int R_DEPTH  = 1,
  parameter int MAX_WR   = 4,
  parameter int MAX_RD   = 4
) (
  axi_lite_channel.slave               master,
  axi_lite_channel.master              slave,
  output logic [$clog2(MAX_WR+1)-1:0]  wr_cnt,
  output logic [$clog2(MAX_RD+1)-1:0]  rd_cnt,
  output logic                         idle,
  output logic                         err
);
  localparam int AWD = $bits(master.aw_addr);
  localparam int DWD = $bits(master.w_data);
  localparam int SWD = $bits(master.w_strb);
  localparam int WCW = $clog2(MAX_WR + 1);
  localparam int RCW = $clog2(MAX_RD + 1);
  localparam logic [WCW-1:0] WR_LIMIT = WCW'(MAX_WR);
  localparam logic [RCW-1:0] RD_LIMIT = RCW'(MAX_RD);

  if ($bits(master.aw_addr) != $bits(slave.aw_addr) ||
      $bits(master.w_data) != $bits(slave.w_data)) begin : g_bad_width
    $fatal(1, "axi_lite_slice: master and slave ADDR_WIDTH/DATA_WIDTH differ");
  end
  if (MAX_WR < 1 || MAX_WR > 255) begin : g_bad_max_wr
    $fatal(1, "axi_lite_slice: MAX_WR must lie in 1..255");
  end
  if (MAX_RD < 1 || MAX_RD > 255) begin : g_bad_max_rd
    $fatal(1, "axi_lite_slice: MAX_RD must lie in 1..255");
  end

  logic clk;
  logic rst_n;
  assign clk   = master.clk;
  assign rst_n = master.rstn;

  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic           err_q, err_d;

  logic wr_block, rd_block;
  logic aw_in_ready, ar_in_ready;
  logic aw_empty, w_empty, b_empty, ar_empty, r_empty;
  logic aw_hs, b_hs, ar_hs, r_hs;

  logic [AWD+2:0]     aw_out;
  logic [DWD+SWD-1:0] w_out;
  logic [AWD+2:0]     ar_out;
  logic [DWD+1:0]     r_out;

  // At the limit the request is hidden from the buffer as well as refused
  // upstream, so both sides of the buffer agree on whether a beat moved.
  assign wr_block = (wr_cnt_q == WR_LIMIT);
  assign rd_block = (rd_cnt_q == RD_LIMIT);

  axi_lite_slice_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AWD + 3)) u_aw (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (master.aw_valid && !wr_block),
    .in_ready_o  (aw_in_ready),
    .in_data_i   ({master.aw_addr, master.aw_prot}),
    .out_valid_o (slave.aw_valid),
    .out_ready_i (slave.aw_ready),
    .out_data_o  (aw_out),
    .empty_o     (aw_empty)
  );
  assign master.aw_ready = aw_in_ready && !wr_block;
  assign {slave.aw_addr, slave.aw_prot} = aw_out;

  axi_lite_slice_fifo #(.DEPTH(W_DEPTH), .WIDTH(DWD + SWD)) u_w (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (master.w_valid),
    .in_ready_o  (master.w_ready),
    .in_data_i   ({master.w_data, master.w_strb}),
    .out_valid_o (slave.w_valid),
    .out_ready_i (slave.w_ready),
    .out_data_o  (w_out),
    .empty_o     (w_empty)
  );
  assign {slave.w_data, slave.w_strb} = w_out;

  axi_lite_slice_fifo #(.DEPTH(B_DEPTH), .WIDTH(2)) u_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (slave.b_valid),
    .in_ready_o  (slave.b_ready),
    .in_data_i   (slave.b_resp),
    .out_valid_o (master.b_valid),
    .out_ready_i (master.b_ready),
    .out_data_o  (master.b_resp),
    .empty_o     (b_empty)
  );

  axi_lite_slice_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AWD + 3)) u_ar (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (master.ar_valid && !rd_block),
    .in_ready_o  (ar_in_ready),
    .in_data_i   ({master.ar_addr, master.ar_prot}),
    .out_valid_o (slave.ar_valid),
    .out_ready_i (slave.ar_ready),
    .out_data_o  (ar_out),
    .empty_o     (ar_empty)
  );
  assign master.ar_ready = ar_in_ready && !rd_block;
  assign {slave.ar_addr, slave.ar_prot} = ar_out;

  axi_lite_slice_fifo #(.DEPTH(R_DEPTH), .WIDTH(DWD + 2)) u_r (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (slave.r_valid),
    .in_ready_o  (slave.r_ready),
    .in_data_i   ({slave.r_data, slave.r_resp}),
    .out_valid_o (master.r_valid),
    .out_ready_i (master.r_ready),
    .out_data_o  (r_out),
    .empty_o     (r_empty)
  );
  assign {master.r_data, master.r_resp} = r_out;

  assign aw_hs = master.aw_valid && master.aw_ready;
  assign b_hs  = master.b_valid  && master.b_ready;
  assign ar_hs = master.ar_valid && master.ar_ready;
  assign r_hs  = master.r_valid  && master.r_ready;

  // A response with nothing outstanding raises err and leaves the count at zero.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    if (b_hs && (wr_cnt_q == '0)) begin
      err_d = 1'b1;
    end
    if (r_hs && (rd_cnt_q == '0)) begin
      err_d = 1'b1;
    end
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + WCW'(1);
    end else if (b_hs && !aw_hs && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - WCW'(1);
    end
    if (ar_hs && !r_hs) begin
      rd_cnt_d = rd_cnt_q + RCW'(1);
    end else if (r_hs && !ar_hs && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - RCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
  assign err    = err_q;
  assign idle   = (wr_cnt_q == '0) && (rd_cnt_q == '0) &&
                  aw_empty && w_empty && b_empty && ar_empty && r_empty;
endmodule

// File: tb/tb_axi_lite_slice.sv
// Bench for axi_lite_slice: directed scenarios on three configurations, then
// randomized traffic on the default configuration against a queue-based model.
module tb_axi_lite_slice;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ma (.clk(clk), .rstn(rstn));
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sa (.clk(clk), .rstn(rstn));
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mb (.clk(clk), .rstn(rstn));
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sb (.clk(clk), .rstn(rstn));
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mc (.clk(clk), .rstn(rstn));
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sc (.clk(clk), .rstn(rstn));

  logic [2:0] wr_cnt_a, rd_cnt_a, wr_cnt_b, wr_cnt_c, rd_cnt_c;
  logic [1:0] rd_cnt_b;
  logic       idle_a, err_a, idle_b, err_b, idle_c, err_c;

  axi_lite_slice u_a (
    .master(ma.slave), .slave(sa.master),
    .wr_cnt(wr_cnt_a), .rd_cnt(rd_cnt_a), .idle(idle_a), .err(err_a)
  );
  axi_lite_slice #(.AW_DEPTH(2), .R_DEPTH(3), .MAX_RD(2)) u_b (
    .master(mb.slave), .slave(sb.master),
    .wr_cnt(wr_cnt_b), .rd_cnt(rd_cnt_b), .idle(idle_b), .err(err_b)
  );
  axi_lite_slice #(.AW_DEPTH(0), .W_DEPTH(0), .B_DEPTH(0), .AR_DEPTH(0), .R_DEPTH(0)) u_c (
    .master(mc.slave), .slave(sc.master),
    .wr_cnt(wr_cnt_c), .rd_cnt(rd_cnt_c), .idle(idle_c), .err(err_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_all();
    ma.aw_valid = 0; ma.aw_addr = 0; ma.aw_prot = 0; ma.w_valid = 0; ma.w_data = 0;
    ma.w_strb = 0; ma.b_ready = 0; ma.ar_valid = 0; ma.ar_addr = 0; ma.ar_prot = 0; ma.r_ready = 0;
    sa.aw_ready = 0; sa.w_ready = 0; sa.b_valid = 0; sa.b_resp = 0; sa.ar_ready = 0;
    sa.r_valid = 0; sa.r_data = 0; sa.r_resp = 0;
    mb.aw_valid = 0; mb.aw_addr = 0; mb.aw_prot = 0; mb.w_valid = 0; mb.w_data = 0;
    mb.w_strb = 0; mb.b_ready = 0; mb.ar_valid = 0; mb.ar_addr = 0; mb.ar_prot = 0; mb.r_ready = 0;
    sb.aw_ready = 0; sb.w_ready = 0; sb.b_valid = 0; sb.b_resp = 0; sb.ar_ready = 0;
    sb.r_valid = 0; sb.r_data = 0; sb.r_resp = 0;
    mc.aw_valid = 0; mc.aw_addr = 0; mc.aw_prot = 0; mc.w_valid = 0; mc.w_data = 0;
    mc.w_strb = 0; mc.b_ready = 0; mc.ar_valid = 0; mc.ar_addr = 0; mc.ar_prot = 0; mc.r_ready = 0;
    sc.aw_ready = 0; sc.w_ready = 0; sc.b_valid = 0; sc.b_resp = 0; sc.ar_ready = 0;
    sc.r_valid = 0; sc.r_data = 0; sc.r_resp = 0;
  endtask

  task automatic ar_send_b(input logic [31:0] addr, output bit ok);
    ok = 0;
    mb.ar_valid = 1; mb.ar_addr = addr;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      ok = mb.ar_ready;
      tick();
    end
    mb.ar_valid = 0;
  endtask

  // Reference model state for the randomized phase
  logic [34:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [1:0]  b_q[$];
  logic [34:0] ar_q[$];
  logic [33:0] r_q[$];
  logic [31:0] exp_q[$];
  logic [63:0] exp_v;
  int pend_b, pend_r, model_wr, model_rd;
  bit h_maw, h_mw, h_mar, h_sb, h_sr, ok;

  initial begin
    int nb, got, first, last;
    init_all();
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sa_aw_valid", sa.aw_valid, 0);
    chk("rst_sa_w_valid", sa.w_valid, 0);
    chk("rst_sa_ar_valid", sa.ar_valid, 0);
    chk("rst_ma_b_valid", ma.b_valid, 0);
    chk("rst_ma_r_valid", ma.r_valid, 0);
    chk("rst_wr_cnt_a", wr_cnt_a, 0);
    chk("rst_rd_cnt_a", rd_cnt_a, 0);
    chk("rst_idle_a", idle_a, 1);
    chk("rst_err_a", err_a, 0);
    chk("rst_idle_b", idle_b, 1);
    chk("rst_sb_aw_valid", sb.aw_valid, 0);

    // Basic write through the default slice, first beat right after release
    @(negedge clk);
    rstn = 1;
    ma.aw_valid = 1; ma.aw_addr = 32'h100; ma.aw_prot = 0;
    ma.w_valid = 1; ma.w_data = 32'hDEADBEEF; ma.w_strb = 4'hF;
    sa.aw_ready = 1; sa.w_ready = 1;
    #1;
    chk("wr_aw_ready_after_rst", ma.aw_ready, 1);
    chk("wr_w_ready_after_rst", ma.w_ready, 1);
    chk("wr_sa_aw_valid_t0", sa.aw_valid, 0);
    tick();
    ma.aw_valid = 0; ma.w_valid = 0;
    #1;
    chk("wr_sa_aw_valid_t1", sa.aw_valid, 1);
    chk("wr_sa_aw_addr", sa.aw_addr, 32'h100);
    chk("wr_sa_w_valid_t1", sa.w_valid, 1);
    chk("wr_sa_w_data", sa.w_data, 32'hDEADBEEF);
    chk("wr_sa_w_strb", sa.w_strb, 4'hF);
    chk("wr_cnt_after_aw", wr_cnt_a, 1);
    tick();
    sa.b_valid = 1; sa.b_resp = 2'b00; ma.b_ready = 1;
    #1;
    chk("wr_sa_aw_valid_drained", sa.aw_valid, 0);
    chk("wr_ma_b_valid_t0", ma.b_valid, 0);
    tick();
    sa.b_valid = 0;
    #1;
    chk("wr_ma_b_valid_t1", ma.b_valid, 1);
    chk("wr_ma_b_resp", ma.b_resp, 2'b00);
    chk("wr_cnt_before_b", wr_cnt_a, 1);
    tick();
    #1;
    chk("wr_cnt_after_b", wr_cnt_a, 0);
    chk("wr_idle_after_b", idle_a, 1);
    ma.b_ready = 0;

    // Read throttling with MAX_RD=2
    sb.ar_ready = 1; mb.r_ready = 1;
    ar_send_b(32'h10, ok);
    chk("rd_ar0_accepted", ok, 1);
    ar_send_b(32'h20, ok);
    chk("rd_ar1_accepted", ok, 1);
    mb.ar_valid = 1; mb.ar_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rd_ar2_blocked", mb.ar_ready, 0);
      chk("rd_cnt_at_limit", rd_cnt_b, 2);
      tick();
    end
    sb.r_valid = 1; sb.r_data = 32'hA1; sb.r_resp = 0;
    #1;
    chk("rd_sb_r_ready", sb.r_ready, 1);
    tick();
    sb.r_valid = 0;
    #1;
    chk("rd_mb_r_valid", mb.r_valid, 1);
    chk("rd_mb_r_data", mb.r_data, 32'hA1);
    chk("rd_ar2_still_blocked", mb.ar_ready, 0);
    tick();
    #1;
    chk("rd_cnt_after_r", rd_cnt_b, 1);
    chk("rd_ar2_unblocked", mb.ar_ready, 1);
    tick();
    mb.ar_valid = 0;
    #1;
    chk("rd_cnt_after_ar2", rd_cnt_b, 2);
    mb.r_ready = 0;
    repeat (2) tick();

    // R buffer of depth 3 filling then streaming
    nb = 1; got = 0; first = -1; last = -1;
    exp_q.delete();
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      sb.r_valid = (nb <= 5);
      sb.r_data = nb;
      mb.r_ready = (cyc >= 8);
      #1;
      if (cyc == 7) begin
        chk("rbuf_accepted", nb - 1, 3);
        chk("rbuf_slave_ready_low", sb.r_ready, 0);
      end
      if (sb.r_valid && sb.r_ready) begin
        exp_q.push_back(nb);
        nb++;
      end
      if (mb.r_valid && mb.r_ready) begin
        exp_v = 'x;
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        chk("rbuf_order", mb.r_data, exp_v);
        if (first >= 0) chk("rbuf_no_gap", cyc, last + 1);
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      tick();
    end
    sb.r_valid = 0; mb.r_ready = 0;
    chk("rbuf_delivered", got, 5);
    chk("rbuf_rd_cnt_zero", rd_cnt_b, 0);
    chk("rbuf_err_unsolicited", err_b, 1);

    // All-zero-depth slice: wires, with counting and gating intact
    mc.aw_valid = 1; mc.aw_addr = 32'h55; sc.aw_ready = 0;
    #1;
    chk("p0_aw_valid_thru", sc.aw_valid, 1);
    chk("p0_aw_addr_thru", sc.aw_addr, 32'h55);
    chk("p0_aw_ready_thru_low", mc.aw_ready, 0);
    sc.aw_ready = 1;
    #1;
    chk("p0_aw_ready_thru_high", mc.aw_ready, 1);
    tick();
    for (int i = 1; i < 4; i++) begin
      mc.aw_addr = 32'h55 + i;
      #1;
      chk("p0_aw_ready_below_max", mc.aw_ready, 1);
      tick();
    end
    mc.aw_addr = 32'h99;
    sc.b_valid = 1; sc.b_resp = 2'b10; mc.b_ready = 0;
    #1;
    chk("p0_wr_cnt_max", wr_cnt_c, 4);
    chk("p0_aw_gated", mc.aw_ready, 0);
    chk("p0_aw_valid_gated", sc.aw_valid, 0);
    chk("p0_b_valid_thru", mc.b_valid, 1);
    chk("p0_b_resp_thru", mc.b_resp, 2'b10);
    chk("p0_b_ready_thru_low", sc.b_ready, 0);
    mc.b_ready = 1;
    #1;
    chk("p0_b_with_aw_at_max", mc.aw_ready, 0);
    chk("p0_b_ready_thru_high", sc.b_ready, 1);
    tick();
    sc.b_valid = 0; mc.b_ready = 0;
    #1;
    chk("p0_wr_cnt_after_b", wr_cnt_c, 3);
    chk("p0_aw_reopened", mc.aw_ready, 1);
    tick();
    mc.aw_valid = 0;
    mc.w_valid = 1; mc.w_data = 32'h1234; sc.w_ready = 0;
    sc.r_valid = 1; sc.r_data = 32'h77; mc.r_ready = 0;
    #1;
    chk("p0_wr_cnt_back_max", wr_cnt_c, 4);
    chk("p0_w_valid_thru", sc.w_valid, 1);
    chk("p0_w_data_thru", sc.w_data, 32'h1234);
    chk("p0_r_valid_thru", mc.r_valid, 1);
    chk("p0_r_data_thru", mc.r_data, 32'h77);
    sc.w_ready = 1;
    #1;
    chk("p0_w_not_gated", mc.w_ready, 1);
    chk("p0_idle_low", idle_c, 0);
    mc.w_valid = 0; sc.w_ready = 0; sc.r_valid = 0;
    tick();

    // Unsolicited B on the default slice
    sa.b_valid = 1; sa.b_resp = 2'b01; ma.b_ready = 1;
    #1;
    chk("ub_b_not_yet", ma.b_valid, 0);
    tick();
    sa.b_valid = 0;
    #1;
    chk("ub_b_visible", ma.b_valid, 1);
    chk("ub_err_before", err_a, 0);
    tick();
    #1;
    chk("ub_err_set", err_a, 1);
    chk("ub_wr_cnt_zero", wr_cnt_a, 0);
    ma.b_ready = 0;
    repeat (3) tick();
    chk("ub_err_sticky", err_a, 1);

    // Asynchronous reset with two AWs parked in a depth-2 buffer
    sb.aw_ready = 0;
    mb.aw_valid = 1; mb.aw_addr = 32'hA0;
    #1;
    chk("ar_aw0_ready", mb.aw_ready, 1);
    tick();
    mb.aw_addr = 32'hB0;
    #1;
    chk("ar_aw1_ready", mb.aw_ready, 1);
    tick();
    mb.aw_valid = 0;
    #1;
    chk("ar_wr_cnt_two", wr_cnt_b, 2);
    chk("ar_sb_aw_valid", sb.aw_valid, 1);
    chk("ar_sb_aw_addr", sb.aw_addr, 32'hA0);
    #1;
    rstn = 0;
    #1;
    chk("ar_aw_valid_dropped", sb.aw_valid, 0);
    chk("ar_wr_cnt_cleared", wr_cnt_b, 0);
    chk("ar_idle_b", idle_b, 1);
    chk("ar_err_b_cleared", err_b, 0);
    chk("ar_err_a_cleared", err_a, 0);
    chk("ar_wr_cnt_c_cleared", wr_cnt_c, 0);
    tick();
    sb.aw_ready = 1;
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_no_stale_aw", sb.aw_valid, 0);
    end
    chk("ar_wr_cnt_after", wr_cnt_b, 0);
    chk("ar_idle_after", idle_b, 1);
    sb.aw_ready = 0;

    // Randomized traffic on the default slice
    pend_b = 0; pend_r = 0; model_wr = 0; model_rd = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      bit gen;
      gen = (cyc < 400);
      if (gen && !ma.aw_valid && $urandom_range(0, 1) == 1) begin
        ma.aw_valid = 1; ma.aw_addr = $urandom; ma.aw_prot = 3'($urandom_range(0, 7));
      end
      if (gen && !ma.w_valid && $urandom_range(0, 1) == 1) begin
        ma.w_valid = 1; ma.w_data = $urandom; ma.w_strb = 4'($urandom_range(0, 15));
      end
      if (gen && !ma.ar_valid && $urandom_range(0, 1) == 1) begin
        ma.ar_valid = 1; ma.ar_addr = $urandom; ma.ar_prot = 3'($urandom_range(0, 7));
      end
      ma.b_ready  = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      ma.r_ready  = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      sa.aw_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      sa.w_ready  = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      sa.ar_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!sa.b_valid && pend_b > 0 && $urandom_range(0, 1) == 1) begin
        sa.b_valid = 1; sa.b_resp = 2'($urandom_range(0, 3));
      end
      if (!sa.r_valid && pend_r > 0 && $urandom_range(0, 1) == 1) begin
        sa.r_valid = 1; sa.r_data = $urandom; sa.r_resp = 2'($urandom_range(0, 3));
      end
      #1;
      chk("rnd_wr_cnt", wr_cnt_a, model_wr);
      chk("rnd_rd_cnt", rd_cnt_a, model_rd);
      if (model_wr == 4) chk("rnd_aw_gate", ma.aw_ready, 0);
      if (model_rd == 4) chk("rnd_ar_gate", ma.ar_ready, 0);
      h_maw = ma.aw_valid && ma.aw_ready;
      h_mw  = ma.w_valid && ma.w_ready;
      h_mar = ma.ar_valid && ma.ar_ready;
      h_sb  = sa.b_valid && sa.b_ready;
      h_sr  = sa.r_valid && sa.r_ready;
      if (h_maw) begin
        aw_q.push_back({ma.aw_addr, ma.aw_prot});
        model_wr++;
      end
      if (h_mw) w_q.push_back({ma.w_data, ma.w_strb});
      if (h_mar) begin
        ar_q.push_back({ma.ar_addr, ma.ar_prot});
        model_rd++;
      end
      if (sa.aw_valid && sa.aw_ready) begin
        exp_v = 'x;
        if (aw_q.size() != 0) exp_v = aw_q.pop_front();
        chk("rnd_aw_payload", {sa.aw_addr, sa.aw_prot}, exp_v);
        pend_b++;
      end
      if (sa.w_valid && sa.w_ready) begin
        exp_v = 'x;
        if (w_q.size() != 0) exp_v = w_q.pop_front();
        chk("rnd_w_payload", {sa.w_data, sa.w_strb}, exp_v);
      end
      if (sa.ar_valid && sa.ar_ready) begin
        exp_v = 'x;
        if (ar_q.size() != 0) exp_v = ar_q.pop_front();
        chk("rnd_ar_payload", {sa.ar_addr, sa.ar_prot}, exp_v);
        pend_r++;
      end
      if (h_sb) begin
        b_q.push_back(sa.b_resp);
        pend_b--;
      end
      if (h_sr) begin
        r_q.push_back({sa.r_data, sa.r_resp});
        pend_r--;
      end
      if (ma.b_valid && ma.b_ready) begin
        exp_v = 'x;
        if (b_q.size() != 0) exp_v = b_q.pop_front();
        chk("rnd_b_payload", ma.b_resp, exp_v);
        model_wr--;
      end
      if (ma.r_valid && ma.r_ready) begin
        exp_v = 'x;
        if (r_q.size() != 0) exp_v = r_q.pop_front();
        chk("rnd_r_payload", {ma.r_data, ma.r_resp}, exp_v);
        model_rd--;
      end
      tick();
      if (h_maw) ma.aw_valid = 0;
      if (h_mw)  ma.w_valid = 0;
      if (h_mar) ma.ar_valid = 0;
      if (h_sb)  sa.b_valid = 0;
      if (h_sr)  sa.r_valid = 0;
    end
    #1;
    chk("rnd_drain_aw_q", aw_q.size(), 0);
    chk("rnd_drain_w_q", w_q.size(), 0);
    chk("rnd_drain_ar_q", ar_q.size(), 0);
    chk("rnd_drain_wr_cnt", wr_cnt_a, 0);
    chk("rnd_drain_rd_cnt", rd_cnt_a, 0);
    chk("rnd_drain_idle", idle_a, 1);
    chk("rnd_no_err", err_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time budget exhausted");
  end
endmodule
